// File: rtl/convolutional_decode_13_if.sv
// Symbol-in / bit-out handshake bundle for convolutional_decode_13.
//   sym_valid/sym_a/sym_b/sym_ready : received code symbol (out1, out2) from the slicer
//   bit_valid/bit_data/bit_err/bit_ready : decoded data bit plus parity-disagreement flag
// master = the side that sources symbols and sinks bits; slave = the decoder.
interface convolutional_decode_13_if;
  logic sym_valid;
  logic sym_a;
  logic sym_b;
  logic sym_ready;
  logic bit_valid;
  logic bit_data;
  logic bit_err;
  logic bit_ready;

  modport master (
    output sym_valid, sym_a, sym_b, bit_ready,
    input  sym_ready, bit_valid, bit_data, bit_err
  );

  modport slave (
    input  sym_valid, sym_a, sym_b, bit_ready,
    output sym_ready, bit_valid, bit_data, bit_err
  );
endinterface

// File: rtl/convolutional_decode_13.sv
// Hard-decision, decision-feedback decoder for the rate-1/2, 13-stage
// convolutional code. Each accepted symbol yields one data bit (recovered
// from the out1 stream) and an error flag when the out2 stream disagrees.
// Ports:
//   clock, reset : rising-edge clock, synchronous active-high reset
//   restart      : one-cycle pulse, leaves FAULT and clears decode history
//   s            : symbol input / decoded bit output handshake (slave side)
//   fault        : high while in FAULT
//   err_count    : saturating count of errored symbols since reset
module convolutional_decode_13 #(
  parameter int ERR_LIMIT = 4,
  parameter int CNT_W     = 16
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     restart,
  convolutional_decode_13_if.slave s,
  output logic                     fault,
  output logic [CNT_W-1:0]         err_count
);

  typedef enum logic {RUN = 1'b0, FAULT = 1'b1} state_t;

  state_t           state_q, state_d;
  logic [12:1]      h_q, h_d;            // h_q[1] is the most recently decoded bit
  logic [3:0]       run_q, run_d;        // consecutive errored symbols
  logic [CNT_W-1:0] err_count_q, err_count_d;
  logic             bit_valid_q, bit_valid_d;
  logic             bit_data_q, bit_data_d;
  logic             bit_err_q, bit_err_d;

  logic p1, p2, err;
  logic accept, decode, hit_limit;

  // Strip the known contribution of past data from each parity stream; what is
  // left in each is the current data bit, so the two must agree.
  assign p1  = s.sym_a ^ h_q[4] ^ h_q[6] ^ h_q[8] ^ h_q[9] ^ h_q[11] ^ h_q[12];
  assign p2  = s.sym_b ^ h_q[1] ^ h_q[2] ^ h_q[3] ^ h_q[4] ^ h_q[5] ^ h_q[7]
             ^ h_q[8] ^ h_q[12];
  assign err = p1 ^ p2;

  assign accept = s.sym_valid & s.sym_ready;
  // A symbol arriving with restart, or while faulted, is consumed but dropped.
  assign decode = accept & (state_q == RUN) & !restart;
  // run never exceeds ERR_LIMIT-1 in RUN, so the 4-bit sum cannot wrap.
  assign hit_limit = decode & err & ((run_q + 4'd1) == 4'(ERR_LIMIT));

  // State register
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= RUN;
      h_q         <= '0;
      run_q       <= '0;
      err_count_q <= '0;
      bit_valid_q <= 1'b0;
      bit_data_q  <= 1'b0;
      bit_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      h_q         <= h_d;
      run_q       <= run_d;
      err_count_q <= err_count_d;
      bit_valid_q <= bit_valid_d;
      bit_data_q  <= bit_data_d;
      bit_err_q   <= bit_err_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      RUN:     if (hit_limit) state_d = FAULT;
      FAULT:   if (restart)   state_d = RUN;
      default: state_d = RUN;
    endcase
  end

  // Outputs
  always_comb begin
    // Faulted: swallow symbols unconditionally so the upstream never stalls.
    s.sym_ready = (state_q == FAULT) | !bit_valid_q | s.bit_ready;
    fault       = (state_q == FAULT);
    s.bit_valid = bit_valid_q;
    s.bit_data  = bit_data_q;
    s.bit_err   = bit_err_q;
    err_count   = err_count_q;
  end

  // Datapath: history, counters and the single-entry output register
  always_comb begin
    h_d         = h_q;
    run_d       = run_q;
    err_count_d = err_count_q;
    bit_valid_d = bit_valid_q & !s.bit_ready;
    bit_data_d  = bit_data_q;
    bit_err_d   = bit_err_q;
    if (restart) begin
      h_d   = '0;
      run_d = '0;
    end else if (decode) begin
      h_d         = {h_q[11:1], p1};
      bit_valid_d = 1'b1;
      bit_data_d  = p1;
      bit_err_d   = err;
      if (err) begin
        run_d = run_q + 4'd1;
        if (err_count_q != '1) err_count_d = err_count_q + CNT_W'(1);
      end else begin
        run_d = '0;
      end
    end
  end

endmodule

// File: tb/tb_convolutional_decode_13.sv
module tb_convolutional_decode_13;
  logic clock = 1'b0;
  logic reset, restart;
  logic sv, sa, sb, br;
  int   pass_cnt = 0;
  int   tot_cnt  = 0;
  logic [12:1] eh;   // reference encoder history, eh[1] = last data bit

  convolutional_decode_13_if bus16();
  convolutional_decode_13_if bus2();

  assign bus16.sym_valid = sv;
  assign bus16.sym_a     = sa;
  assign bus16.sym_b     = sb;
  assign bus16.bit_ready = br;
  assign bus2.sym_valid  = sv;
  assign bus2.sym_a      = sa;
  assign bus2.sym_b      = sb;
  assign bus2.bit_ready  = br;

  logic        fault16, fault2;
  logic [15:0] ec16;
  logic [1:0]  ec2;

  convolutional_decode_13 #(.ERR_LIMIT(4), .CNT_W(16)) dut (
    .clock(clock), .reset(reset), .restart(restart),
    .s(bus16), .fault(fault16), .err_count(ec16)
  );

  convolutional_decode_13 #(.ERR_LIMIT(4), .CNT_W(2)) dut2 (
    .clock(clock), .reset(reset), .restart(restart),
    .s(bus2), .fault(fault2), .err_count(ec2)
  );

  always #5 clock = ~clock;

  // Encoder model: r0 = u, r_k = eh[k]
  function automatic logic enc_a(input logic u, input logic [12:1] h);
    return u ^ h[4] ^ h[6] ^ h[8] ^ h[9] ^ h[11] ^ h[12];
  endfunction
  function automatic logic enc_b(input logic u, input logic [12:1] h);
    return u ^ h[1] ^ h[2] ^ h[3] ^ h[4] ^ h[5] ^ h[7] ^ h[8] ^ h[12];
  endfunction

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic put(input logic u, input logic flip_b);
    sv = 1'b1;
    sa = enc_a(u, eh);
    sb = enc_b(u, eh) ^ flip_b;
  endtask

  task automatic adv(input logic u);
    eh = {eh[11:1], u};
  endtask

  task automatic do_restart();
    sv = 1'b0; restart = 1'b1;
    tick();
    restart = 1'b0;
    eh = '0;
  endtask

  task automatic test_reset();
    reset = 1'b1; restart = 1'b0; sv = 1'b0; sa = 1'b0; sb = 1'b0; br = 1'b1; eh = '0;
    tick(); tick();
    tot_cnt++; if (bus16.sym_ready !== 1'b1) $display("FAIL reset_sym_ready got %b want 1", bus16.sym_ready); else pass_cnt++;
    tot_cnt++; if (bus16.bit_valid !== 1'b0) $display("FAIL reset_bit_valid got %b want 0", bus16.bit_valid); else pass_cnt++;
    tot_cnt++; if (bus16.bit_data !== 1'b0) $display("FAIL reset_bit_data got %b want 0", bus16.bit_data); else pass_cnt++;
    tot_cnt++; if (bus16.bit_err !== 1'b0) $display("FAIL reset_bit_err got %b want 0", bus16.bit_err); else pass_cnt++;
    tot_cnt++; if (fault16 !== 1'b0) $display("FAIL reset_fault got %b want 0", fault16); else pass_cnt++;
    tot_cnt++; if (ec16 !== 16'd0) $display("FAIL reset_err_count got %0d want 0", ec16); else pass_cnt++;
    tot_cnt++; if (ec2 !== 2'd0 || bus2.bit_valid !== 1'b0) $display("FAIL reset_dut2 got ec=%0d valid=%b want 0/0", ec2, bus2.bit_valid); else pass_cnt++;
    reset = 1'b0;
  endtask

  task automatic test_impulse();
    logic [12:0] a_tab, b_tab;
    logic        want;
    a_tab = 13'h1B51;   // n = 0,4,6,8,9,11,12
    b_tab = 13'h11BF;   // n = 0,1,2,3,4,5,7,8,12
    for (int n = 0; n < 13; n++) begin
      sv = 1'b1; sa = a_tab[n]; sb = b_tab[n];
      want = (n == 0);
      tick();
      adv(want);
      tot_cnt++;
      if (bus16.bit_valid !== 1'b1 || bus16.bit_data !== want || bus16.bit_err !== 1'b0)
        $display("FAIL impulse_bit%0d got v=%b d=%b e=%b want v=1 d=%b e=0", n, bus16.bit_valid, bus16.bit_data, bus16.bit_err, want);
      else pass_cnt++;
    end
    sv = 1'b0;
    tick();
    tot_cnt++; if (ec16 !== 16'd0) $display("FAIL impulse_err_count got %0d want 0", ec16); else pass_cnt++;
    tot_cnt++; if (bus16.bit_valid !== 1'b0) $display("FAIL impulse_drain got %b want 0", bus16.bit_valid); else pass_cnt++;
  endtask

  task automatic test_stream();
    int   bad = 0;
    int   first = -1;
    logic u;
    for (int n = 0; n < 1000; n++) begin
      u = 1'($urandom_range(1, 0));
      put(u, 1'b0);
      tick();
      adv(u);
      if (bus16.bit_valid !== 1'b1 || bus16.bit_data !== u || bus16.bit_err !== 1'b0) begin
        bad++;
        if (first < 0) first = n;
      end
    end
    sv = 1'b0;
    tot_cnt++; if (bad != 0) $display("FAIL stream_decode got %0d bad bits (first at %0d) want 0", bad, first); else pass_cnt++;
    tot_cnt++; if (ec16 !== 16'd0) $display("FAIL stream_err_count got %0d want 0", ec16); else pass_cnt++;
  endtask

  task automatic test_restart_run();
    // Symbol presented together with restart must be dropped.
    sv = 1'b1; sa = 1'b1; sb = 1'b0; restart = 1'b1;
    tick();
    restart = 1'b0; sv = 1'b0; eh = '0;
    tot_cnt++; if (bus16.bit_valid !== 1'b0) $display("FAIL restart_run_discard got %b want 0", bus16.bit_valid); else pass_cnt++;
    tot_cnt++; if (fault16 !== 1'b0) $display("FAIL restart_run_fault got %b want 0", fault16); else pass_cnt++;
  endtask

  task automatic test_single_flip();
    int   bad = 0;
    logic u;
    for (int n = 0; n < 40; n++) begin
      u = 1'($urandom_range(1, 0));
      put(u, n == 20);
      tick();
      adv(u);
      if (n == 20) begin
        tot_cnt++; if (bus16.bit_err !== 1'b1) $display("FAIL flip_bit_err got %b want 1", bus16.bit_err); else pass_cnt++;
        tot_cnt++; if (bus16.bit_data !== u) $display("FAIL flip_bit_data got %b want %b", bus16.bit_data, u); else pass_cnt++;
      end else if (bus16.bit_valid !== 1'b1 || bus16.bit_data !== u || bus16.bit_err !== 1'b0) begin
        bad++;
      end
    end
    sv = 1'b0;
    tot_cnt++; if (bad != 0) $display("FAIL flip_other_bits got %0d bad want 0", bad); else pass_cnt++;
    tot_cnt++; if (ec16 !== 16'd1) $display("FAIL flip_err_count got %0d want 1", ec16); else pass_cnt++;
  endtask

  task automatic test_fault();
    logic u;
    int   bad = 0;
    do_restart();
    for (int k = 0; k < 4; k++) begin
      u = 1'($urandom_range(1, 0));
      put(u, 1'b1);
      tick();
      adv(u);
      tot_cnt++;
      if (bus16.bit_valid !== 1'b1 || bus16.bit_err !== 1'b1 || bus16.bit_data !== u)
        $display("FAIL fault_err_bit%0d got v=%b d=%b e=%b want v=1 d=%b e=1", k, bus16.bit_valid, bus16.bit_data, bus16.bit_err, u);
      else pass_cnt++;
      tot_cnt++; if (fault16 !== (k == 3)) $display("FAIL fault_flag%0d got %b want %b", k, fault16, (k == 3)); else pass_cnt++;
    end
    // Pending errored bit must be held while downstream stalls.
    br = 1'b0;
    put(1'b1, 1'b0);
    tick();
    tot_cnt++; if (bus16.bit_valid !== 1'b1 || bus16.bit_err !== 1'b1) $display("FAIL fault_hold got v=%b e=%b want 1/1", bus16.bit_valid, bus16.bit_err); else pass_cnt++;
    tot_cnt++; if (bus16.sym_ready !== 1'b1) $display("FAIL fault_sym_ready got %b want 1", bus16.sym_ready); else pass_cnt++;
    br = 1'b1;
    for (int k = 0; k < 3; k++) begin
      put(1'($urandom_range(1, 0)), 1'b0);
      tick();
      tot_cnt++; if (bus16.bit_valid !== 1'b0) $display("FAIL fault_no_valid%0d got %b want 0", k, bus16.bit_valid); else pass_cnt++;
    end
    tot_cnt++; if (ec16 !== 16'd5) $display("FAIL fault_err_count got %0d want 5", ec16); else pass_cnt++;
    do_restart();
    tot_cnt++; if (fault16 !== 1'b0) $display("FAIL fault_restart got %b want 0", fault16); else pass_cnt++;
    for (int n = 0; n < 20; n++) begin
      u = 1'($urandom_range(1, 0));
      put(u, 1'b0);
      tick();
      adv(u);
      if (bus16.bit_valid !== 1'b1 || bus16.bit_data !== u || bus16.bit_err !== 1'b0) bad++;
    end
    sv = 1'b0;
    tot_cnt++; if (bad != 0) $display("FAIL fault_after_restart got %0d bad want 0", bad); else pass_cnt++;
    tot_cnt++; if (ec16 !== 16'd5) $display("FAIL fault_count_kept got %0d want 5", ec16); else pass_cnt++;
  endtask

  task automatic test_backpressure();
    logic [3:0] us;
    us = 4'b1101;   // u0=1, u1=0, u2=1, u3=1
    do_restart();
    put(us[0], 1'b0);
    tick();
    adv(us[0]);
    br = 1'b0;
    put(us[1], 1'b0);
    for (int k = 0; k < 5; k++) begin
      tick();
      tot_cnt++; if (bus16.sym_ready !== 1'b0) $display("FAIL bp_sym_ready%0d got %b want 0", k, bus16.sym_ready); else pass_cnt++;
      tot_cnt++;
      if (bus16.bit_valid !== 1'b1 || bus16.bit_data !== us[0] || bus16.bit_err !== 1'b0)
        $display("FAIL bp_hold%0d got v=%b d=%b e=%b want v=1 d=%b e=0", k, bus16.bit_valid, bus16.bit_data, bus16.bit_err, us[0]);
      else pass_cnt++;
    end
    br = 1'b1;
    tick();
    adv(us[1]);
    tot_cnt++; if (bus16.bit_valid !== 1'b1 || bus16.bit_data !== us[1]) $display("FAIL bp_take_accept got v=%b d=%b want v=1 d=%b", bus16.bit_valid, bus16.bit_data, us[1]); else pass_cnt++;
    for (int k = 2; k < 4; k++) begin
      put(us[k], 1'b0);
      tick();
      adv(us[k]);
      tot_cnt++; if (bus16.bit_valid !== 1'b1 || bus16.bit_data !== us[k]) $display("FAIL bp_bit%0d got v=%b d=%b want v=1 d=%b", k, bus16.bit_valid, bus16.bit_data, us[k]); else pass_cnt++;
    end
    sv = 1'b0;
    tick();
    tot_cnt++; if (bus16.bit_valid !== 1'b0) $display("FAIL bp_drop got %b want 0", bus16.bit_valid); else pass_cnt++;
  endtask

  task automatic test_reset_mid();
    logic u, f;
    int   bad = 0;
    reset = 1'b1; sv = 1'b0;
    tick();
    reset = 1'b0; eh = '0;
    for (int n = 0; n < 50; n++) begin
      u = 1'($urandom_range(1, 0));
      f = (n == 5 || n == 15 || n == 25 || n == 35 || n == 45);
      put(u, f);
      tick();
      adv(u);
      if (bus16.bit_data !== u || bus16.bit_err !== f) bad++;
    end
    tot_cnt++; if (bad != 0) $display("FAIL mid_pre_decode got %0d bad want 0", bad); else pass_cnt++;
    tot_cnt++; if (ec2 !== 2'd3) $display("FAIL mid_sat_count got %0d want 3", ec2); else pass_cnt++;
    tot_cnt++; if (ec16 !== 16'd5) $display("FAIL mid_wide_count got %0d want 5", ec16); else pass_cnt++;
    tot_cnt++; if (fault16 !== 1'b0 || fault2 !== 1'b0) $display("FAIL mid_no_fault got %b/%b want 0/0", fault16, fault2); else pass_cnt++;
    put(1'b1, 1'b0);
    reset = 1'b1;
    tick();
    reset = 1'b0; eh = '0;
    tot_cnt++;
    if (bus16.bit_valid !== 1'b0 || bus16.bit_data !== 1'b0 || bus16.bit_err !== 1'b0 || fault16 !== 1'b0 || ec16 !== 16'd0)
      $display("FAIL mid_reset_outputs got v=%b d=%b e=%b f=%b c=%0d want all 0", bus16.bit_valid, bus16.bit_data, bus16.bit_err, fault16, ec16);
    else pass_cnt++;
    tot_cnt++; if (ec2 !== 2'd0 || bus2.bit_valid !== 1'b0) $display("FAIL mid_reset_dut2 got c=%0d v=%b want 0/0", ec2, bus2.bit_valid); else pass_cnt++;
    bad = 0;
    for (int n = 0; n < 30; n++) begin
      u = 1'($urandom_range(1, 0));
      put(u, 1'b0);
      tick();
      adv(u);
      if (bus16.bit_valid !== 1'b1 || bus16.bit_data !== u || bus16.bit_err !== 1'b0) bad++;
      if (bus2.bit_valid !== 1'b1 || bus2.bit_data !== u || bus2.bit_err !== 1'b0) bad++;
    end
    sv = 1'b0;
    tot_cnt++; if (bad != 0) $display("FAIL mid_post_decode got %0d bad want 0", bad); else pass_cnt++;
    tot_cnt++; if (ec2 !== 2'd0) $display("FAIL mid_post_count got %0d want 0", ec2); else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_impulse();
    test_stream();
    test_restart_run();
    test_single_flip();
    test_fault();
    test_backpressure();
    test_reset_mid();
    $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
    $finish;
  end

endmodule
